// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: byte-masked write port, packed read ports,
// clear request and status flags.
interface regfile_param_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   logic [XLEN/8-1:0]   we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic                clr_req;
   logic                busy;
   logic                wr_drop;

   modport master (
      output we, wa, wd, ra, clr_req,
      input  rd, busy, wr_drop
   );

   modport slave (
      input  we, wa, wd, ra, clr_req,
      output rd, busy, wr_drop
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: x0 hardwired to zero, byte-masked write port,
// combinational read ports with optional write-first bypass, sequential clear.
//
// state | meaning
// IDLE  | normal operation, writes commit, reads return entries
// CLEAR | zeroing entry idx each cycle; reads masked to 0, writes dropped
module regfile_param #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_param_if.slave bus
);
   localparam int AW = $clog2(NREG);
   localparam int NB = XLEN / 8;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state;
   logic [AW-1:0]   idx;
   logic            busy_q;
   logic            wr_drop_q;
   logic [XLEN-1:0] mem [NREG];

   logic wr_any;
   logic wr_en;

   // A write to x0 is a no-op everywhere, so it never counts as dropped.
   assign wr_any = (bus.we != '0) && (bus.wa != '0);
   assign wr_en  = (state == IDLE) && !bus.clr_req && !rst && wr_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         idx       <= AW'(1);
         busy_q    <= 1'b1;
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= wr_any && ((state == CLEAR) || bus.clr_req);
         case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state  <= CLEAR;
                  idx    <= AW'(1);
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (idx == AW'(NREG - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state  <= CLEAR;
               idx    <= AW'(1);
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset so it can map onto distributed RAM; entry 0 is never
   // written and never read.
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst) begin
         mem[idx] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.we[b]) mem[bus.wa][8*b +: 8] <= bus.wd[8*b +: 8];
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.wr_drop = wr_drop_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] stored;
      logic [XLEN-1:0] fwd;
      logic            hit;

      assign a      = bus.ra[k*AW +: AW];
      assign stored = mem[a];
      assign hit    = (BYPASS != 0) && (state == IDLE) && (bus.we != '0) && (bus.wa == a);

      always_comb begin
         fwd = stored;
         for (int b = 0; b < NB; b++) begin
            if (bus.we[b]) fwd[8*b +: 8] = bus.wd[8*b +: 8];
         end
      end

      assign bus.rd[k*XLEN +: XLEN] = (busy_q || a == '0) ? '0 : (hit ? fwd : stored);
   end
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: drives a BYPASS=1 and a BYPASS=0
// instance in lockstep and compares both against an array model.
module tb_regfile_param;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]        we;
   logic [AW-1:0]     wa;
   logic [XLEN-1:0]   wd;
   logic [NRD*AW-1:0] ra;
   logic              clr_req;

   regfile_param_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus1 ();
   regfile_param_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();

   assign bus1.we = we;  assign bus1.wa = wa;  assign bus1.wd = wd;
   assign bus1.ra = ra;  assign bus1.clr_req = clr_req;
   assign bus0.we = we;  assign bus0.wa = wa;  assign bus0.wd = wd;
   assign bus0.ra = ra;  assign bus0.clr_req = clr_req;

   regfile_param #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));
   regfile_param #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));

   int errors = 0;
   int checks = 0;
   logic [XLEN-1:0] model [NREG];

   function automatic logic [XLEN-1:0] merge(logic [XLEN-1:0] old, logic [XLEN-1:0] d,
                                             logic [3:0] m);
      logic [XLEN-1:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Expected read in IDLE for the current write-port inputs.
   function automatic logic [XLEN-1:0] expect_rd(int a, bit byp);
      if (a == 0) return '0;
      if (byp && we != 0 && int'(wa) == a) return merge(model[a], wd, we);
      return model[a];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = '0; wa = '0; wd = '0; ra = '0; clr_req = 1'b0;
   endtask

   task automatic commit_model();
      if (we != 0 && wa != 0 && !clr_req) model[wa] = merge(model[wa], wd, we);
   endtask

   task automatic zero_model();
      for (int i = 0; i < NREG; i++) model[i] = '0;
   endtask

   task automatic do_write(int a, logic [XLEN-1:0] d, logic [3:0] m);
      wa = AW'(a); wd = d; we = m;
      commit_model();
      step();
      we = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      zero_model();
      checks++;
      if (bus1.busy !== 1'b1 || bus0.busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy got %b/%b want 1", bus1.busy, bus0.busy);
      end
      checks++;
      if (bus1.wr_drop !== 1'b0 || bus0.wr_drop !== 1'b0) begin
         errors++; $display("FAIL reset_wr_drop got %b/%b want 0", bus1.wr_drop, bus0.wr_drop);
      end
      for (int k = 1; k <= 31; k++) begin
         ra = NRD*AW'($urandom);
         #1;
         checks++;
         if (bus1.rd !== '0 || bus0.rd !== '0) begin
            errors++; $display("FAIL reset_rd_masked k=%0d got %h/%h want 0", k, bus1.rd, bus0.rd);
         end
         step();
         checks++;
         if (bus1.busy !== (k < 31) || bus0.busy !== (k < 31)) begin
            errors++;
            $display("FAIL reset_busy_len k=%0d got %b/%b want %b", k, bus1.busy, bus0.busy, k < 31);
         end
      end
      for (int a = 0; a < NREG; a++) begin
         ra = {AW'(a), AW'(a)};
         #1;
         checks++;
         if (bus1.rd !== '0 || bus0.rd !== '0) begin
            errors++; $display("FAIL reset_zero a=%0d got %h/%h want 0", a, bus1.rd, bus0.rd);
         end
      end
      ra = '0;
   endtask

   task automatic test_byte_write();
      do_write(5, 32'hAABBCCDD, 4'b1111);
      do_write(5, 32'h11223344, 4'b0101);
      ra = {AW'(0), AW'(5)};
      #1;
      checks++;
      if (bus1.rd[31:0] !== 32'hAA22CC44 || bus0.rd[31:0] !== 32'hAA22CC44) begin
         errors++;
         $display("FAIL byte_write got %h/%h want aa22cc44", bus1.rd[31:0], bus0.rd[31:0]);
      end
      checks++;
      if (bus1.wr_drop !== 1'b0 || bus0.wr_drop !== 1'b0) begin
         errors++; $display("FAIL byte_write_drop got %b/%b want 0", bus1.wr_drop, bus0.wr_drop);
      end
   endtask

   task automatic test_bypass();
      do_write(7, 32'h12345678, 4'b1111);
      wa = AW'(7); wd = 32'hFFFFFFFF; we = 4'b0011;
      ra = {AW'(7), AW'(0)};
      #1;
      checks++;
      if (bus1.rd[63:32] !== 32'h1234FFFF) begin
         errors++; $display("FAIL bypass_on_pre got %h want 1234ffff", bus1.rd[63:32]);
      end
      checks++;
      if (bus0.rd[63:32] !== 32'h12345678) begin
         errors++; $display("FAIL bypass_off_pre got %h want 12345678", bus0.rd[63:32]);
      end
      checks++;
      if (bus1.rd[31:0] !== '0 || bus0.rd[31:0] !== '0) begin
         errors++; $display("FAIL bypass_port0_x0 got %h/%h want 0", bus1.rd[31:0], bus0.rd[31:0]);
      end
      commit_model();
      step();
      we = '0;
      #1;
      checks++;
      if (bus1.rd[63:32] !== 32'h1234FFFF || bus0.rd[63:32] !== 32'h1234FFFF) begin
         errors++;
         $display("FAIL bypass_post got %h/%h want 1234ffff", bus1.rd[63:32], bus0.rd[63:32]);
      end
   endtask

   task automatic test_x0();
      wa = '0; wd = 32'hDEADBEEF; we = 4'b1111; ra = '0;
      #1;
      checks++;
      if (bus1.rd !== '0 || bus0.rd !== '0) begin
         errors++; $display("FAIL x0_pre got %h/%h want 0", bus1.rd, bus0.rd);
      end
      step();
      we = '0;
      checks++;
      if (bus1.wr_drop !== 1'b0 || bus0.wr_drop !== 1'b0) begin
         errors++; $display("FAIL x0_drop got %b/%b want 0", bus1.wr_drop, bus0.wr_drop);
      end
      checks++;
      if (bus1.rd !== '0 || bus0.rd !== '0) begin
         errors++; $display("FAIL x0_post got %h/%h want 0", bus1.rd, bus0.rd);
      end
   endtask

   task automatic test_clr_drop();
      do_write(3, 32'hCAFEF00D, 4'b1111);
      do_write(9, 32'h0BADBEEF, 4'b1111);
      clr_req = 1'b1; wa = AW'(3); wd = 32'h55555555; we = 4'b1111;
      step();
      clr_req = 1'b0; we = '0;
      zero_model();
      checks++;
      if (bus1.wr_drop !== 1'b1 || bus0.wr_drop !== 1'b1) begin
         errors++; $display("FAIL clr_drop_pulse got %b/%b want 1", bus1.wr_drop, bus0.wr_drop);
      end
      checks++;
      if (bus1.busy !== 1'b1 || bus0.busy !== 1'b1) begin
         errors++; $display("FAIL clr_busy_start got %b/%b want 1", bus1.busy, bus0.busy);
      end
      for (int k = 1; k <= 31; k++) begin
         if (k == 5) begin wa = AW'(12); wd = 32'h77777777; we = 4'b1111; end
         if (k == 8) clr_req = 1'b1;
         step();
         we = '0; clr_req = 1'b0;
         checks++;
         if (bus1.busy !== (k < 31) || bus0.busy !== (k < 31)) begin
            errors++;
            $display("FAIL clr_busy_len k=%0d got %b/%b want %b", k, bus1.busy, bus0.busy, k < 31);
         end
         checks++;
         if (bus1.wr_drop !== (k == 5) || bus0.wr_drop !== (k == 5)) begin
            errors++;
            $display("FAIL clr_wr_drop k=%0d got %b/%b want %b", k, bus1.wr_drop, bus0.wr_drop, k == 5);
         end
      end
      ra = {AW'(9), AW'(3)};
      #1;
      checks++;
      if (bus1.rd !== '0 || bus0.rd !== '0) begin
         errors++; $display("FAIL clr_entries got %h/%h want 0", bus1.rd, bus0.rd);
      end
      ra = {AW'(12), AW'(12)};
      #1;
      checks++;
      if (bus1.rd !== '0 || bus0.rd !== '0) begin
         errors++; $display("FAIL clr_dropped_write got %h/%h want 0", bus1.rd, bus0.rd);
      end
   endtask

   task automatic test_rst_mid_clear();
      for (int i = 0; i < 20; i++) do_write(int'($urandom_range(1, NREG-1)), $urandom, 4'b1111);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int k = 1; k < 10; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      zero_model();
      for (int k = 1; k <= 31; k++) begin
         checks++;
         if (bus1.busy !== 1'b1 || bus0.busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy k=%0d got %b/%b want 1", k, bus1.busy, bus0.busy);
         end
         step();
      end
      checks++;
      if (bus1.busy !== 1'b0 || bus0.busy !== 1'b0) begin
         errors++; $display("FAIL midrst_busy_end got %b/%b want 0", bus1.busy, bus0.busy);
      end
      for (int a = 0; a < NREG; a++) begin
         ra = {AW'(a), AW'(a)};
         #1;
         checks++;
         if (bus1.rd !== '0 || bus0.rd !== '0) begin
            errors++; $display("FAIL midrst_zero a=%0d got %h/%h want 0", a, bus1.rd, bus0.rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         wa = AW'($urandom);
         wd = $urandom;
         we = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         ra = NRD*AW'($urandom);
         if (i % 7 == 0) ra[2*AW-1:AW] = wa;
         #1;
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (bus1.rd[p*XLEN +: XLEN] !== expect_rd(int'(ra[p*AW +: AW]), 1'b1)) begin
               errors++;
               $display("FAIL rand_byp1 i=%0d p=%0d got %h want %h", i, p,
                        bus1.rd[p*XLEN +: XLEN], expect_rd(int'(ra[p*AW +: AW]), 1'b1));
            end
            checks++;
            if (bus0.rd[p*XLEN +: XLEN] !== expect_rd(int'(ra[p*AW +: AW]), 1'b0)) begin
               errors++;
               $display("FAIL rand_byp0 i=%0d p=%0d got %h want %h", i, p,
                        bus0.rd[p*XLEN +: XLEN], expect_rd(int'(ra[p*AW +: AW]), 1'b0));
            end
         end
         commit_model();
         step();
         checks++;
         if (bus1.wr_drop !== 1'b0 || bus0.wr_drop !== 1'b0) begin
            errors++; $display("FAIL rand_drop i=%0d got %b/%b want 0", i, bus1.wr_drop, bus0.wr_drop);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      zero_model();
      test_reset();
      test_byte_write();
      test_bypass();
      test_x0();
      test_clr_drop();
      test_back_to_back();
      test_rst_mid_clear();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
